mysum_multi: RTL and testbench

//   Multi-channel Avalon-MM byte-sum accumulator, the parametrised successor to the single-accumulator byte summer.

---
 rtl/mysum_multi.sv | 121 ++++++++++++
 tb/tb_mysum_multi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mysum_multi.sv
// NCHAN-channel Avalon-MM byte-sum accumulator (wrap/saturate, sticky overflow).
// Read data registered, 1-cycle latency; no waitrequest, every access completes when presented.
module mysum_multi #(
    parameter  int NCHAN  = 4,
    parameter  int DATA_W = 32,
    parameter  int ACC_W  = 32,
    localparam int NB     = DATA_W / 8,
    localparam int ADDR_W = $clog2(NCHAN) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [NB-1:0]     byteenable
);
    localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int BS_W = 8 + $clog2(NB);
    localparam int PC_W = $clog2(NB + 1);
    localparam logic [ACC_W-1:0] ONES = '1;

    logic [ACC_W-1:0]  acc_q [NCHAN];
    logic [ACC_W-1:0]  acc_d [NCHAN];
    logic [ACC_W-1:0]  cnt_q [NCHAN];
    logic [ACC_W-1:0]  cnt_d [NCHAN];
    logic [NCHAN-1:0]  sat_q, sat_d;
    logic [NCHAN-1:0]  ovf_q, ovf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvld_q, rvld_d;

    logic [CH_W-1:0]   sel;
    logic [1:0]        rsel;
    logic [BS_W-1:0]   bsum;
    logic [PC_W-1:0]   pcnt;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W:0]    cnt_sum;

    assign sel  = CH_W'(address >> 2);
    assign rsel = address[1:0];

    // Lane sum is wide enough that it can never lose a carry.
    always_comb begin
        bsum = '0;
        pcnt = '0;
        for (int i = 0; i < NB; i++) begin
            if (byteenable[i]) begin
                bsum = bsum + BS_W'(writedata[8*i +: 8]);
                pcnt = pcnt + PC_W'(1);
            end
        end
        acc_sum = {1'b0, acc_q[sel]} + (ACC_W+1)'(bsum);
        cnt_sum = {1'b0, cnt_q[sel]} + (ACC_W+1)'(pcnt);
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        rdata_d = '0;
        rvld_d  = 1'b0;
        if (write) begin
            case (rsel)
                2'd0: begin
                    if (acc_sum[ACC_W]) begin
                        acc_d[sel] = sat_q[sel] ? ONES : acc_sum[ACC_W-1:0];
                        ovf_d[sel] = 1'b1;
                    end else begin
                        acc_d[sel] = acc_sum[ACC_W-1:0];
                    end
                    cnt_d[sel] = cnt_sum[ACC_W] ? ONES : cnt_sum[ACC_W-1:0];
                end
                2'd1: begin
                    acc_d[sel] = '0;
                    cnt_d[sel] = '0;
                    ovf_d[sel] = 1'b0;
                end
                2'd3: begin
                    sat_d[sel] = writedata[0];
                    if (writedata[1]) ovf_d[sel] = 1'b0;
                end
                default: ;
            endcase
        end else if (read) begin
            // A read coinciding with a write is dropped; only a lone read responds.
            rvld_d = 1'b1;
            case (rsel)
                2'd0:    rdata_d = DATA_W'(acc_q[sel]);
                2'd2:    rdata_d = DATA_W'(cnt_q[sel]);
                2'd3:    rdata_d = DATA_W'({ovf_q[sel], sat_q[sel]});
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            sat_q   <= '0;
            ovf_q   <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvld_q;
endmodule

// File: tb/tb_mysum_multi.sv
// Directed table-driven bench for mysum_multi; a 16-bit accumulator keeps wrap/saturate
// boundaries reachable in a few dozen adds.
module tb_mysum_multi;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    int nchk  = 0;
    int nfail = 0;

    mysum_multi #(.NCHAN(4), .DATA_W(32), .ACC_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rep;
        bit          exp_vld;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vq[$];

    function automatic logic [3:0] a(int ch, int r);
        return 4'(ch * 4 + r);
    endfunction

    function automatic void push(bit wr, bit rd, logic [3:0] ad, logic [31:0] wd,
                                 logic [3:0] be, int rep, bit ev, logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = ad; v.wdata = wd; v.be = be;
        v.rep = rep; v.exp_vld = ev; v.exp_dat = ed;
        vq.push_back(v);
    endfunction

    function automatic void vw(logic [3:0] ad, logic [31:0] wd, logic [3:0] be, int rep);
        push(1'b1, 1'b0, ad, wd, be, rep, 1'b0, 32'h0);
    endfunction

    function automatic void vr(logic [3:0] ad, logic [31:0] ed);
        push(1'b0, 1'b1, ad, 32'h0, 4'h0, 1, 1'b1, ed);
    endfunction

    function automatic void vrw(logic [3:0] ad, logic [31:0] wd, logic [3:0] be);
        push(1'b1, 1'b1, ad, wd, be, 1, 1'b0, 32'h0);
    endfunction

    function automatic void vi();
        push(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 32'h0);
    endfunction

    task automatic check(string nm, bit ev, logic [31:0] ed);
        nchk++;
        if (readdatavalid !== ev || readdata !== ed) begin
            nfail++;
            $display("FAIL %s: got vld=%0b data=%h, want vld=%0b data=%h",
                     nm, readdatavalid, readdata, ev, ed);
        end
    endtask

    // Entered and left on a negedge; consecutive vectors land in consecutive cycles.
    task automatic run_table(string tag);
        for (int i = 0; i < vq.size(); i++) begin
            for (int r = 0; r < vq[i].rep; r++) begin
                write      = vq[i].wr;
                read       = vq[i].rd;
                address    = vq[i].addr;
                writedata  = vq[i].wdata;
                byteenable = vq[i].be;
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("%s[%0d] addr=%h", tag, i, vq[i].addr), vq[i].exp_vld, vq[i].exp_dat);
        end
        write = 1'b0;
        read  = 1'b0;
        vq.delete();
    endtask

    initial begin
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 1'b0, 32'h0);
        reset_n = 1'b1;

        // Reset values of every register, back-to-back reads.
        for (int ch = 0; ch < 4; ch++)
            for (int r = 0; r < 4; r++)
                vr(a(ch, r), 32'h0);
        vi();

        // ch0 lane sums and count, be=0 is a no-op.
        vw(a(0, 0), 32'h0102_0304, 4'hF, 1);
        vw(a(0, 0), 32'h0102_0304, 4'b0101, 1);
        vr(a(0, 0), 32'h10);
        vr(a(0, 2), 32'd6);
        vw(a(0, 0), 32'hFFFF_FFFF, 4'h0, 1);
        vr(a(0, 0), 32'h10);
        vr(a(0, 2), 32'd6);

        // ch3 baseline that must survive everything else.
        vw(a(3, 0), 32'h11, 4'h1, 1);
        vw(a(3, 3), 32'h1, 4'hF, 1);
        vr(a(3, 3), 32'h1);

        // ch1 wrap and write-1-to-clear.
        vw(a(1, 0), 32'hFFFF_FFFF, 4'hF, 64);
        vw(a(1, 0), 32'h0000_00F0, 4'h1, 1);
        vr(a(1, 0), 32'hFFF0);
        vr(a(1, 3), 32'h0);
        vr(a(1, 2), 32'd257);
        vw(a(1, 0), 32'h0000_0020, 4'h1, 1);
        vr(a(1, 0), 32'h10);
        vr(a(1, 3), 32'h2);
        vw(a(1, 3), 32'h2, 4'hF, 1);
        vr(a(1, 3), 32'h0);
        vr(a(1, 2), 32'd258);
        vw(a(1, 1), 32'hDEAD, 4'hF, 1);
        vr(a(1, 0), 32'h0);
        vr(a(1, 2), 32'h0);
        vr(a(1, 1), 32'h0);

        // ch2 saturate, sticky OVF, re-set when pinned at all ones.
        vw(a(2, 3), 32'h1, 4'hF, 1);
        vw(a(2, 0), 32'hFFFF_FFFF, 4'hF, 64);
        vw(a(2, 0), 32'h0000_00FF, 4'h1, 1);
        vr(a(2, 0), 32'hFFFF);
        vr(a(2, 3), 32'h1);
        vw(a(2, 0), 32'h0000_00FF, 4'h1, 1);
        vr(a(2, 0), 32'hFFFF);
        vr(a(2, 3), 32'h3);
        vw(a(2, 3), 32'h1, 4'hF, 1);
        vr(a(2, 3), 32'h3);
        vw(a(2, 3), 32'h3, 4'hF, 1);
        vr(a(2, 3), 32'h1);
        vw(a(2, 0), 32'h0000_0001, 4'h1, 1);
        vr(a(2, 0), 32'hFFFF);
        vr(a(2, 3), 32'h3);
        vr(a(2, 2), 32'd259);
        vw(a(2, 1), 32'h1234_5678, 4'hF, 1);
        vr(a(2, 3), 32'h1);
        vr(a(2, 0), 32'h0);
        vr(a(2, 2), 32'h0);

        vr(a(3, 0), 32'h11);
        vr(a(3, 2), 32'd1);
        vr(a(3, 3), 32'h1);

        // Simultaneous read+write: write wins, no response.
        vrw(a(0, 0), 32'h5, 4'h1);
        vr(a(0, 0), 32'h15);
        vr(a(0, 2), 32'd7);
        vi();
        vw(a(0, 2), 32'hFFFF, 4'hF, 1);
        vr(a(0, 2), 32'd7);
        vw(a(0, 3), 32'h1, 4'hF, 1);
        vr(a(0, 3), 32'h1);
        vi();
        run_table("main");

        // Reset lands between a read's acceptance and its use.
        address = a(0, 0);
        read    = 1'b1;
        write   = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        read = 1'b0;
        #1 check("rst_drops_resp", 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        vi();
        vr(a(0, 0), 32'h0);
        vr(a(0, 2), 32'h0);
        vr(a(0, 3), 32'h0);
        vr(a(1, 0), 32'h0);
        vr(a(2, 3), 32'h0);
        vr(a(3, 0), 32'h0);
        vr(a(3, 3), 32'h0);
        vi();
        run_table("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
